// File: rtl/dnn_pkg.sv
// dnn_pkg
//   Shared sizes, load-order word indices, FSM state encoding and a width helper
//   for the dnn host controller and its operand register file.
package dnn_pkg;

   localparam int DATA_W  = 5;    // operand width, two's complement
   localparam int OUT_W   = 17;   // result width, two's complement
   localparam int N_WORDS = 28;   // 4 x + 16 layer-1 weights + 8 layer-2 weights

   // Position of each operand group in the load stream
   localparam int IDX_X0  = 0;
   localparam int IDX_W04 = 4;
   localparam int IDX_W48 = 20;

   // Counter width that stays legal when a count is 1
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int CNT_W = cnt_width(N_WORDS);

   // Controller states, kept as plain constants so legacy tools accept them
   typedef logic [1:0] state_t;
   localparam state_t ST_LOAD   = 2'd0;
   localparam state_t ST_FIRE   = 2'd1;
   localparam state_t ST_RESULT = 2'd2;
   localparam state_t ST_GAP    = 2'd3;

endpackage

// File: rtl/dnn_ld_regfile.sv
// dnn_ld_regfile
//   Write-indexed operand store. Each accepted load word lands at its stream
//   index; every entry is visible at once on a flat bus, entry 0 in the LSBs.
// Ports
//   clk      in   clock, all logic on posedge
//   rst_n    in   synchronous active-low reset, clears every entry
//   we_i     in   write enable
//   waddr_i  in   entry index to write
//   wdata_i  in   word to write
//   flat_o   out  all entries concatenated, entry i at [i*WORD_W +: WORD_W]
module dnn_ld_regfile
   import dnn_pkg::*;
#(
   parameter int WORD_W = DATA_W,
   parameter int DEPTH  = N_WORDS,
   parameter int ADDR_W = cnt_width(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we_i,
   input  logic [ADDR_W-1:0]         waddr_i,
   input  logic [WORD_W-1:0]         wdata_i,
   output logic [DEPTH*WORD_W-1:0]   flat_o
);

   logic signed [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign flat_o[g*WORD_W +: WORD_W] = mem_q[g];
   end

endmodule

// File: rtl/dnn_host_ctrl.sv
// dnn_host_ctrl
//   Host-side initiator for the dnn core. Collects a 28-word serial load into
//   parallel operand buses, presents them with in_ready, captures the two dnn
//   results on their strobes (or gives up after TIMEOUT_CYC cycles), hands the
//   pair downstream over valid/ready, then waits GAP_CYC cycles before the next
//   load.
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   ld_valid/ld_ready/ld_data  serial load word handshake
//   dnn_x, dnn_w1, dnn_w2      operand buses to dnn (load order, first word in LSBs)
//   in_ready                   operands valid and stable to dnn
//   out0/out1, out0_ready/out1_ready   dnn results and their valid strobes
//   res_valid/res_ready        result handshake downstream
//   res_out0, res_out1         captured results (0 after a timeout)
//   res_timeout                result produced by timeout
//   busy                       controller not in LOAD
module dnn_host_ctrl
   import dnn_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int GAP_CYC     = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [DATA_W-1:0]     ld_data,
   output logic [4*DATA_W-1:0]   dnn_x,
   output logic [16*DATA_W-1:0]  dnn_w1,
   output logic [8*DATA_W-1:0]   dnn_w2,
   output logic                  in_ready,
   input  logic [OUT_W-1:0]      out0,
   input  logic [OUT_W-1:0]      out1,
   input  logic                  out0_ready,
   input  logic                  out1_ready,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [OUT_W-1:0]      res_out0,
   output logic [OUT_W-1:0]      res_out1,
   output logic                  res_timeout,
   output logic                  busy
);

   localparam int TMR_W = cnt_width(TIMEOUT_CYC);
   localparam int GAP_W = cnt_width(GAP_CYC);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_WORDS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   state_t                     state_q, state_d;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic [TMR_W-1:0]           tmr_q, tmr_d;
   logic [GAP_W-1:0]           gap_q, gap_d;
   logic                       got0_q, got0_d;
   logic                       got1_q, got1_d;
   logic signed [OUT_W-1:0]    res0_q, res0_d;
   logic signed [OUT_W-1:0]    res1_q, res1_d;
   logic                       tmo_q, tmo_d;
   logic                       ld_ready_q;
   logic                       ld_we;
   logic [N_WORDS*DATA_W-1:0]  words_flat;

   dnn_ld_regfile #(
      .WORD_W (DATA_W),
      .DEPTH  (N_WORDS),
      .ADDR_W (CNT_W)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (ld_we),
      .waddr_i (cnt_q),
      .wdata_i (ld_data),
      .flat_o  (words_flat)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      gap_d   = gap_q;
      got0_d  = got0_q;
      got1_d  = got1_q;
      res0_d  = res0_q;
      res1_d  = res1_q;
      tmo_d   = tmo_q;
      ld_we   = 1'b0;

      case (state_q)
         ST_LOAD: begin
            // ld_ready_q is only ever high in LOAD, so this is the accept strobe
            if (ld_valid && ld_ready_q) begin
               ld_we = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  cnt_d   = '0;
                  tmr_d   = '0;
                  state_d = ST_FIRE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         ST_FIRE: begin
            tmr_d = tmr_q + 1'b1;
            // Only the first strobe of each result is kept
            if (out0_ready && !got0_q) begin
               got0_d = 1'b1;
               res0_d = out0;
            end
            if (out1_ready && !got1_q) begin
               got1_d = 1'b1;
               res1_d = out1;
            end
            // Completion wins over a timeout landing in the same cycle
            if (got0_d && got1_d) begin
               state_d = ST_RESULT;
            end else if (tmr_q == TMR_LAST) begin
               state_d = ST_RESULT;
               tmo_d   = 1'b1;
               res0_d  = '0;
               res1_d  = '0;
            end
         end

         ST_RESULT: begin
            if (res_ready) begin
               state_d = ST_GAP;
               got0_d  = 1'b0;
               got1_d  = 1'b0;
               tmo_d   = 1'b0;
               tmr_d   = '0;
               gap_d   = '0;
            end
         end

         ST_GAP: begin
            if (gap_q == GAP_LAST) begin
               gap_d   = '0;
               state_d = ST_LOAD;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_LOAD;
         cnt_q      <= '0;
         tmr_q      <= '0;
         gap_q      <= '0;
         got0_q     <= 1'b0;
         got1_q     <= 1'b0;
         res0_q     <= '0;
         res1_q     <= '0;
         tmo_q      <= 1'b0;
         ld_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tmr_q      <= tmr_d;
         gap_q      <= gap_d;
         got0_q     <= got0_d;
         got1_q     <= got1_d;
         res0_q     <= res0_d;
         res1_q     <= res1_d;
         tmo_q      <= tmo_d;
         // Registered so ld_ready stays low while reset is held and rises after release
         ld_ready_q <= (state_d == ST_LOAD);
      end
   end

   assign ld_ready    = ld_ready_q;
   assign in_ready    = (state_q == ST_FIRE);
   assign res_valid   = (state_q == ST_RESULT);
   assign busy        = (state_q != ST_LOAD);
   assign res_out0    = res0_q;
   assign res_out1    = res1_q;
   assign res_timeout = tmo_q;

   assign dnn_x  = words_flat[IDX_W04*DATA_W-1 : IDX_X0*DATA_W];
   assign dnn_w1 = words_flat[IDX_W48*DATA_W-1 : IDX_W04*DATA_W];
   assign dnn_w2 = words_flat[N_WORDS*DATA_W-1 : IDX_W48*DATA_W];

endmodule
